// File: rtl/dmem_lane_adapter.sv
// Cortex-M0 data port to synchronous SRAM bridge: byte-lane steering, read extraction, DRDY/DERR completion.
// Optional feature: define DMEM_ALIGN_TRAP_EN to trap misaligned half/word accesses instead of force-aligning them.
module dmem_lane_adapter #(
  parameter int AW      = 12,
  parameter bit RD_ZERO = 1'b1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          DREQ,
  input  logic [31:0]   DADDR,
  input  logic          DRW,
  input  logic [1:0]    DSIZE,
  input  logic          DSIGN,
  input  logic [31:0]   DOUT,
  output logic [31:0]   DIN,
  output logic          DRDY,
  output logic          DERR,
  output logic          MCSN,
  output logic [AW-1:0] MADDR,
  output logic          MWE,
  output logic [3:0]    MBE,
  output logic [31:0]   MDI,
  input  logic [31:0]   MDO
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

  state_t          state_q;
  logic            rw_q;
  logic [1:0]      size_q;
  logic [1:0]      alow_q;
  logic            sign_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     din_q;
  logic            drdy_q;
  logic            derr_q;
  logic            mcsn_q;
  logic [AW-1:0]   maddr_q;
  logic            mwe_q;
  logic [3:0]      mbe_q;
  logic [31:0]     mdi_q;

  logic            misalign_d;
  logic            illegal_d;
  logic [3:0]      be_d;
  logic [31:0]     mdi_d;
  logic [7:0]      rd_byte_d;
  logic [15:0]     rd_half_d;
  logic [31:0]     rd_ext_d;

  // Address bits above the SRAM word range alias by design.
  logic            unused_addr;
  assign unused_addr = ^DADDR[31:AW+2];

  always_comb begin
    misalign_d = 1'b0;
`ifdef DMEM_ALIGN_TRAP_EN
    misalign_d = ((DSIZE == 2'b01) && DADDR[0]) ||
                 ((DSIZE == 2'b10) && (DADDR[1:0] != 2'b00));
`endif
    illegal_d = (DSIZE == 2'b11) || misalign_d;
    case (DSIZE)
      2'b00: begin
        be_d  = 4'b0001 << DADDR[1:0];
        mdi_d = {4{DOUT[7:0]}};
      end
      2'b01: begin
        be_d  = DADDR[1] ? 4'b1100 : 4'b0011;
        mdi_d = {2{DOUT[15:0]}};
      end
      default: begin
        be_d  = 4'b1111;
        mdi_d = DOUT;
      end
    endcase
  end

  // Half and word extraction ignore the low address bits, which gives force-alignment for free.
  always_comb begin
    rd_byte_d = MDO[{alow_q, 3'b000} +: 8];
    rd_half_d = alow_q[1] ? MDO[31:16] : MDO[15:0];
    case (size_q)
      2'b00:   rd_ext_d = {{24{sign_q & rd_byte_d[7]}}, rd_byte_d};
      2'b01:   rd_ext_d = {{16{sign_q & rd_half_d[15]}}, rd_half_d};
      default: rd_ext_d = MDO;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      alow_q  <= 2'b00;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      din_q   <= 32'd0;
      drdy_q  <= 1'b0;
      derr_q  <= 1'b0;
      mcsn_q  <= 1'b1;
      maddr_q <= '0;
      mwe_q   <= 1'b0;
      mbe_q   <= 4'b0000;
      mdi_q   <= 32'd0;
    end else begin
      drdy_q <= 1'b0;
      derr_q <= 1'b0;
      if (RD_ZERO) din_q <= 32'd0;
      case (state_q)
        IDLE: begin
          // The DRDY cycle still carries the finished request, so it is not re-sampled.
          if (DREQ && !drdy_q) begin
            rw_q   <= DRW;
            size_q <= DSIZE;
            alow_q <= DADDR[1:0];
            sign_q <= DSIGN;
            err_q  <= illegal_d;
            if (illegal_d) begin
              state_q <= DONE;
            end else begin
              state_q <= ACCESS;
              mcsn_q  <= 1'b0;
              maddr_q <= DADDR[AW+1:2];
              mwe_q   <= DRW;
              mbe_q   <= be_d;
              mdi_q   <= mdi_d;
            end
          end
        end
        ACCESS: begin
          mcsn_q  <= 1'b1;
          mwe_q   <= 1'b0;
          state_q <= rw_q ? DONE : CAPTURE;
        end
        CAPTURE: begin
          rdata_q <= rd_ext_d;
          state_q <= DONE;
        end
        default: begin
          drdy_q <= 1'b1;
          derr_q <= err_q;
          if (err_q)      din_q <= 32'd0;
          else if (!rw_q) din_q <= rdata_q;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign DIN   = din_q;
  assign DRDY  = drdy_q;
  assign DERR  = derr_q;
  assign MCSN  = mcsn_q;
  assign MADDR = maddr_q;
  assign MWE   = mwe_q;
  assign MBE   = mbe_q;
  assign MDI   = mdi_q;

endmodule

// File: tb/tb_dmem_lane_adapter.sv
// Scoreboard bench for dmem_lane_adapter: byte-array reference memory, SRAM model, directed then random traffic.
module tb_dmem_lane_adapter;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        DREQ;
  logic [31:0] DADDR;
  logic        DRW;
  logic [1:0]  DSIZE;
  logic        DSIGN;
  logic [31:0] DOUT;
  logic [31:0] DIN;
  logic        DRDY;
  logic        DERR;
  logic        MCSN;
  logic [11:0] MADDR;
  logic        MWE;
  logic [3:0]  MBE;
  logic [31:0] MDI;
  logic [31:0] MDO;

  always #5 CLK = ~CLK;

  dmem_lane_adapter dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DADDR(DADDR), .DRW(DRW),
    .DSIZE(DSIZE), .DSIGN(DSIGN), .DOUT(DOUT), .DIN(DIN), .DRDY(DRDY),
    .DERR(DERR), .MCSN(MCSN), .MADDR(MADDR), .MWE(MWE), .MBE(MBE),
    .MDI(MDI), .MDO(MDO)
  );

  // SRAM environment: synchronous read, per-byte write enables.
  logic [31:0] sram [0:4095];
  always @(posedge CLK) begin
    if (MCSN == 1'b0) begin
      if (MWE) begin
        for (int b = 0; b < 4; b++)
          if (MBE[b]) sram[MADDR][8*b +: 8] <= MDI[8*b +: 8];
      end else begin
        MDO <= sram[MADDR];
      end
    end
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0] ref_mem [0:16383];

  typedef struct {
    logic        derr;
    logic [31:0] din;
    int          cyc;
  } resp_t;
  typedef struct {
    logic [11:0] maddr;
    logic        mwe;
    logic [3:0]  mbe;
    logic [31:0] mdi;
  } sram_t;

  resp_t resp_q[$];
  sram_t sram_q[$];
  resp_t mr;
  sram_t ms;
  int    nvec = 0;
  int    nerr = 0;
  int    cyc  = 0;
  bit    mon_en = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a completion or an SRAM access.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (DRDY) begin
        if (resp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_drdy: got DRDY=1 expected no completion (cycle %0d)", cyc);
        end else begin
          mr = resp_q.pop_front();
          check("drdy_latency", cyc, mr.cyc);
          check("derr", {31'd0, DERR}, {31'd0, mr.derr});
          check("din", DIN, mr.din);
          $display("txn done: cycle=%0d derr=%0b din=%h", cyc, DERR, DIN);
        end
      end else begin
        check("din_zero_when_idle", DIN, 32'd0);
      end
      if (MCSN == 1'b0) begin
        if (sram_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_sram_access: got MCSN=0 expected 1 (cycle %0d)", cyc);
        end else begin
          ms = sram_q.pop_front();
          check("maddr", {20'd0, MADDR}, {20'd0, ms.maddr});
          check("mwe", {31'd0, MWE}, {31'd0, ms.mwe});
          check("mbe", {28'd0, MBE}, {28'd0, ms.mbe});
          if (ms.mwe) check("mdi", MDI, ms.mdi);
        end
      end
    end
  end

  // Drive one request, compute its expectations from the byte model, optionally wait for DRDY.
  task automatic issue(input logic [31:0] addr, input logic rw, input logic [1:0] size,
                       input logic sign, input logic [31:0] dout, input bit wait_done);
    int          nb, eff, off, s;
    logic        illegal;
    logic [63:0] val;
    resp_t       r;
    sram_t       e;
    bit          got;
    s  = cyc + 1;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    illegal = (size == 2'd3);
`ifdef DMEM_ALIGN_TRAP_EN
    if (size != 2'd3 && (addr % nb) != 0) illegal = 1'b1;
`endif
    DREQ = 1'b1; DADDR = addr; DRW = rw; DSIZE = size; DSIGN = sign; DOUT = dout;
    $display("txn issue: addr=%h rw=%0b size=%0d sign=%0b dout=%h", addr, rw, size, sign, dout);
    if (illegal) begin
      r.derr = 1'b1; r.din = 32'd0; r.cyc = s + 1;
      resp_q.push_back(r);
    end else begin
      eff = int'(addr % 32'd16384);
      eff = eff - (eff % nb);
      off = eff % 4;
      e.maddr = 12'(eff / 4);
      e.mwe   = rw;
      e.mbe   = 4'(((1 << nb) - 1) << off);
      for (int b = 0; b < 4; b++) e.mdi[8*b +: 8] = dout[8*(b % nb) +: 8];
      sram_q.push_back(e);
      r.derr = 1'b0;
      if (rw) begin
        for (int i = 0; i < nb; i++) ref_mem[eff + i] = dout[8*i +: 8];
        r.din = 32'd0;
        r.cyc = s + 2;
      end else begin
        val = 64'd0;
        for (int i = 0; i < nb; i++) val = val | (64'(ref_mem[eff + i]) << (8 * i));
        if (sign && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
        r.din = val[31:0];
        r.cyc = s + 3;
      end
      resp_q.push_back(r);
    end
    if (wait_done) begin
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
        @(negedge CLK);
        if (DRDY) got = 1'b1;
      end
      if (!got) begin
        nvec++; nerr++;
        $display("FAIL drdy_timeout: got no DRDY expected DRDY within 10 cycles (cycle %0d)", cyc);
      end
      @(posedge CLK); #1;
      DREQ = 1'b0; DADDR = $urandom; DRW = 1'($urandom); DSIZE = 2'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [31:0] a;
    for (int w = 0; w < 4096; w++) begin
      a = $urandom;
      sram[w] = a;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = a[8*b +: 8];
    end
    MDO = 32'd0;

    // Reset held with a pending request.
    RESET_N = 1'b0; DREQ = 1'b1; DADDR = 32'h210; DRW = 1'b0; DSIZE = 2'd2; DSIGN = 1'b0; DOUT = 32'd0;
    repeat (4) begin
      @(negedge CLK);
      check("reset_mcsn", {31'd0, MCSN}, 32'd1);
      check("reset_drdy", {31'd0, DRDY}, 32'd0);
      check("reset_din", DIN, 32'd0);
    end
    @(posedge CLK); #1;
    RESET_N = 1'b1; DREQ = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    issue(32'h210, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 1'b1);
    issue(32'h210, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(32'h213, 1'b1, 2'd0, 1'b0, 32'h0000_00AB, 1'b1);
    issue(32'h213, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1);
    issue(32'h213, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1);
    issue(32'h212, 1'b1, 2'd1, 1'b0, 32'h0000_8001, 1'b1);
    issue(32'h212, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1);
    issue(32'h210, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(32'h210, 1'b0, 2'd3, 1'b0, 32'h0, 1'b1);
    issue(32'h214, 1'b1, 2'd3, 1'b0, 32'hDEAD_BEEF, 1'b1);
    issue(32'h211, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);
    issue(32'h213, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1);
    issue(32'hFFFF_C211, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1);

    // Reset while the read sits in CAPTURE: the completion must vanish.
    issue(32'h210, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0);
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET_N = 1'b0; DREQ = 1'b0;
    resp_q.delete();
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("midop_reset_no_drdy", {31'd0, DRDY}, 32'd0);
    end
    @(posedge CLK); #1;
    issue(32'h210, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1);

    for (int k = 0; k < 250; k++) begin
      a = {$urandom_range(0, 32'h3_FFFF), 14'h0} | 32'($urandom_range(32'h200, 32'h23F));
      issue(a, 1'($urandom), 2'($urandom), 1'($urandom), $urandom, 1'b1);
      n = $urandom_range(0, 2);
      repeat (n) begin
        @(posedge CLK); #1;
      end
    end

    repeat (3) @(posedge CLK);
    #1;
    check("resp_queue_drained", resp_q.size(), 32'd0);
    check("sram_queue_drained", sram_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
